// File: rtl/eater_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eater_ctrl
// Description : Microcoded fetch/execute sequencer for the 8-bit bus computer;
//               decodes opcode, step and flags into bus and register strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module eater_ctrl #(
    parameter int MAX_STEP = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       step_en,
    input  logic [3:0] opcode,
    input  logic       cf,
    input  logic       zf,
    output logic [2:0] step,
    output logic       hlt,
    output logic       mi,
    output logic       ri,
    output logic       ro,
    output logic       io,
    output logic       ii,
    output logic       ai,
    output logic       ao,
    output logic       eo,
    output logic       su,
    output logic       bi,
    output logic       oi,
    output logic       ce,
    output logic       co,
    output logic       j,
    output logic       fi
);

    localparam logic [2:0] LAST_STEP = 3'(MAX_STEP);

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [2:0] step_q, step_d;
    logic       halted_q, halted_d;

    logic w_run, w_hlt_op;
    logic w_mi, w_ri, w_ro, w_io, w_ii, w_ai, w_ao, w_eo;
    logic w_su, w_bi, w_oi, w_ce, w_co, w_j, w_fi;

    assign w_hlt_op = (opcode == OP_HLT) && (step_q == T2);
    assign w_run    = step_en & ~halted_q & ~clr;

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (step_en && !halted_q) begin
            if (w_hlt_op) begin
                halted_d = 1'b1;
            end else if (step_q == LAST_STEP) begin
                step_d = T0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Microcode ROM: one row per (step, opcode); each row drives at most one bus source.
    always_comb begin
        {w_mi, w_ri, w_ro, w_io, w_ii, w_ai, w_ao, w_eo} = 8'b0;
        {w_su, w_bi, w_oi, w_ce, w_co, w_j, w_fi}        = 7'b0;
        case (step_q)
            T0: begin
                w_co = 1'b1; w_mi = 1'b1;
            end
            T1: begin
                w_ro = 1'b1; w_ii = 1'b1; w_ce = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        w_io = 1'b1; w_mi = 1'b1;
                    end
                    OP_LDI: begin
                        w_io = 1'b1; w_ai = 1'b1;
                    end
                    OP_JMP: begin
                        w_io = 1'b1; w_j = 1'b1;
                    end
                    OP_JC: begin
                        w_io = cf; w_j = cf;
                    end
                    OP_JZ: begin
                        w_io = zf; w_j = zf;
                    end
                    OP_OUT: begin
                        w_ao = 1'b1; w_oi = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        w_ro = 1'b1; w_ai = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_ro = 1'b1; w_bi = 1'b1;
                    end
                    OP_STA: begin
                        w_ao = 1'b1; w_ri = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    w_eo = 1'b1; w_ai = 1'b1; w_fi = 1'b1;
                    w_su = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    assign step = step_q;
    assign hlt  = ~clr & (halted_q | (step_en & w_hlt_op));

    assign mi = w_mi & w_run;
    assign ri = w_ri & w_run;
    assign ro = w_ro & w_run;
    assign io = w_io & w_run;
    assign ii = w_ii & w_run;
    assign ai = w_ai & w_run;
    assign ao = w_ao & w_run;
    assign eo = w_eo & w_run;
    assign su = w_su & w_run;
    assign bi = w_bi & w_run;
    assign oi = w_oi & w_run;
    assign ce = w_ce & w_run;
    assign co = w_co & w_run;
    assign j  = w_j  & w_run;
    assign fi = w_fi & w_run;

endmodule
`default_nettype wire

// File: tb/tb_eater_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eater_ctrl
// Description : Vector-table and directed-sequence bench for eater_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eater_ctrl;

    // Strobe vector order: {mi,ri,ro,io,ii,ai,ao,eo,su,bi,oi,ce,co,j,fi}
    localparam logic [14:0] S_MI = 15'h4000;
    localparam logic [14:0] S_RI = 15'h2000;
    localparam logic [14:0] S_RO = 15'h1000;
    localparam logic [14:0] S_IO = 15'h0800;
    localparam logic [14:0] S_II = 15'h0400;
    localparam logic [14:0] S_AI = 15'h0200;
    localparam logic [14:0] S_AO = 15'h0100;
    localparam logic [14:0] S_EO = 15'h0080;
    localparam logic [14:0] S_SU = 15'h0040;
    localparam logic [14:0] S_BI = 15'h0020;
    localparam logic [14:0] S_OI = 15'h0010;
    localparam logic [14:0] S_CE = 15'h0008;
    localparam logic [14:0] S_CO = 15'h0004;
    localparam logic [14:0] S_J  = 15'h0002;
    localparam logic [14:0] S_FI = 15'h0001;
    localparam logic [14:0] FETCH0 = S_CO | S_MI;
    localparam logic [14:0] FETCH1 = S_RO | S_II | S_CE;

    logic       clk = 1'b0;
    logic       clr, step_en, cf, zf;
    logic [3:0] opcode;
    logic [2:0] step;
    logic       hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
    logic [14:0] strobes;

    int n_checks = 0;
    int n_errs   = 0;

    assign strobes = {mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

    eater_ctrl #(.MAX_STEP(4)) dut (
        .clk(clk), .clr(clr), .step_en(step_en), .opcode(opcode), .cf(cf), .zf(zf),
        .step(step), .hlt(hlt),
        .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao), .eo(eo),
        .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        en;
        logic [3:0]  op;
        logic        cf;
        logic        zf;
        logic [2:0]  exp_step;
        logic [14:0] exp_str;
        logic        exp_hlt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic c, input logic e, input logic [3:0] o,
                                input logic fc, input logic fz, input logic [2:0] s,
                                input logic [14:0] st, input logic h);
        vec_t v;
        v.clr = c; v.en = e; v.op = o; v.cf = fc; v.zf = fz;
        v.exp_step = s; v.exp_str = st; v.exp_hlt = h;
        vecs.push_back(v);
    endfunction

    // Independent reference for the enabled, non-halted strobe pattern.
    function automatic logic [14:0] model(input logic [3:0] o, input logic fc,
                                          input logic fz, input int st);
        logic [14:0] r;
        r = '0;
        if (st == 0) r = FETCH0;
        else if (st == 1) r = FETCH1;
        else if (st == 2) begin
            if (o >= 4'h1 && o <= 4'h4) r = S_IO | S_MI;
            else if (o == 4'h5) r = S_IO | S_AI;
            else if (o == 4'h6) r = S_IO | S_J;
            else if (o == 4'h7 && fc) r = S_IO | S_J;
            else if (o == 4'h8 && fz) r = S_IO | S_J;
            else if (o == 4'hE) r = S_AO | S_OI;
        end else if (st == 3) begin
            if (o == 4'h1) r = S_RO | S_AI;
            else if (o == 4'h2 || o == 4'h3) r = S_RO | S_BI;
            else if (o == 4'h4) r = S_AO | S_RI;
        end else if (st == 4) begin
            if (o == 4'h2) r = S_EO | S_AI | S_FI;
            else if (o == 4'h3) r = S_EO | S_AI | S_SU | S_FI;
        end
        return r;
    endfunction

    task automatic check(input string nm, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, check mid-cycle, then clock.
    task automatic cyc(input string nm, input int idx, input logic c, input logic e,
                       input logic [3:0] o, input logic fc, input logic fz,
                       input logic [2:0] s, input logic [14:0] st, input logic h);
        int drivers;
        clr = c; step_en = e; opcode = o; cf = fc; zf = fz;
        #1;
        check({nm, ".step"}, idx, {13'd0, step}, {13'd0, s});
        check({nm, ".strobes"}, idx, {1'b0, strobes}, {1'b0, st});
        check({nm, ".hlt"}, idx, {15'd0, hlt}, {15'd0, h});
        drivers = int'(ro) + int'(io) + int'(ao) + int'(eo) + int'(co);
        check({nm, ".bus_one"}, idx, {15'd0, drivers <= 1}, 16'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b1; step_en = 1'b1; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
        @(posedge clk);
        #1;

        // clr held, fetch of NOP, wrap 4->0
        add(1, 1, 4'h0, 0, 0, 3'd0, '0, 0);
        add(0, 1, 4'h0, 0, 0, 3'd0, FETCH0, 0);
        add(0, 1, 4'h0, 0, 0, 3'd1, FETCH1, 0);
        add(0, 1, 4'h0, 0, 0, 3'd2, '0, 0);
        add(0, 1, 4'h0, 0, 0, 3'd3, '0, 0);
        add(0, 1, 4'h0, 0, 0, 3'd4, '0, 0);
        add(0, 1, 4'h3, 0, 0, 3'd0, FETCH0, 0);
        add(0, 1, 4'h3, 0, 0, 3'd1, FETCH1, 0);
        // SUB
        add(0, 1, 4'h3, 0, 0, 3'd2, S_IO | S_MI, 0);
        add(0, 1, 4'h3, 0, 0, 3'd3, S_RO | S_BI, 0);
        add(0, 1, 4'h3, 0, 0, 3'd4, S_EO | S_AI | S_SU | S_FI, 0);
        // ADD
        add(0, 1, 4'h2, 0, 0, 3'd0, FETCH0, 0);
        add(0, 1, 4'h2, 0, 0, 3'd1, FETCH1, 0);
        add(0, 1, 4'h2, 0, 0, 3'd2, S_IO | S_MI, 0);
        add(0, 1, 4'h2, 0, 0, 3'd3, S_RO | S_BI, 0);
        add(0, 1, 4'h2, 0, 0, 3'd4, S_EO | S_AI | S_FI, 0);
        // JC taken / not taken
        add(0, 1, 4'h7, 1, 0, 3'd0, FETCH0, 0);
        add(0, 1, 4'h7, 1, 0, 3'd1, FETCH1, 0);
        add(0, 1, 4'h7, 1, 0, 3'd2, S_IO | S_J, 0);
        add(0, 1, 4'h7, 1, 0, 3'd3, '0, 0);
        add(0, 1, 4'h7, 1, 0, 3'd4, '0, 0);
        add(0, 1, 4'h7, 0, 1, 3'd0, FETCH0, 0);
        add(0, 1, 4'h7, 0, 1, 3'd1, FETCH1, 0);
        add(0, 1, 4'h7, 0, 1, 3'd2, '0, 0);
        add(0, 1, 4'h7, 0, 1, 3'd3, '0, 0);
        add(0, 1, 4'h7, 0, 1, 3'd4, '0, 0);
        // JZ taken / not taken
        add(0, 1, 4'h8, 0, 1, 3'd0, FETCH0, 0);
        add(0, 1, 4'h8, 0, 1, 3'd1, FETCH1, 0);
        add(0, 1, 4'h8, 0, 1, 3'd2, S_IO | S_J, 0);
        add(0, 1, 4'h8, 0, 1, 3'd3, '0, 0);
        add(0, 1, 4'h8, 0, 1, 3'd4, '0, 0);
        add(0, 1, 4'h8, 1, 0, 3'd0, FETCH0, 0);
        add(0, 1, 4'h8, 1, 0, 3'd1, FETCH1, 0);
        add(0, 1, 4'h8, 1, 0, 3'd2, '0, 0);
        add(0, 1, 4'h8, 1, 0, 3'd3, '0, 0);
        add(0, 1, 4'h8, 1, 0, 3'd4, '0, 0);
        // LDA with step_en dropped for 3 cycles at T1
        add(0, 1, 4'h1, 0, 0, 3'd0, FETCH0, 0);
        add(0, 0, 4'h1, 0, 0, 3'd1, '0, 0);
        add(0, 0, 4'h1, 0, 0, 3'd1, '0, 0);
        add(0, 0, 4'h1, 0, 0, 3'd1, '0, 0);
        add(0, 1, 4'h1, 0, 0, 3'd1, FETCH1, 0);
        add(0, 1, 4'h1, 0, 0, 3'd2, S_IO | S_MI, 0);
        add(0, 1, 4'h1, 0, 0, 3'd3, S_RO | S_AI, 0);
        add(0, 1, 4'h1, 0, 0, 3'd4, '0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc("table", i, vecs[i].clr, vecs[i].en, vecs[i].op, vecs[i].cf, vecs[i].zf,
                vecs[i].exp_step, vecs[i].exp_str, vecs[i].exp_hlt);
        end

        // HLT: halt at T2, frozen for 10 cycles regardless of step_en, clr exits
        cyc("halt", 0, 0, 1, 4'hF, 0, 0, 3'd0, FETCH0, 0);
        cyc("halt", 1, 0, 1, 4'hF, 0, 0, 3'd1, FETCH1, 0);
        cyc("halt", 2, 0, 1, 4'hF, 0, 0, 3'd2, '0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc("halted", i, 0, (i % 3) != 0, (i < 5) ? 4'hF : 4'h6, 1, 1, 3'd2, '0, 1);
        end
        cyc("halt_clr", 0, 1, 1, 4'h6, 0, 0, 3'd2, '0, 0);
        cyc("halt_clr", 1, 0, 1, 4'h6, 0, 0, 3'd0, FETCH0, 0);
        cyc("halt_clr", 2, 0, 1, 4'h6, 0, 0, 3'd1, FETCH1, 0);
        cyc("halt_clr", 3, 0, 1, 4'h6, 0, 0, 3'd2, S_IO | S_J, 0);

        // Reset mid-instruction aborts it
        cyc("abort", 0, 1, 1, 4'h3, 0, 0, 3'd3, '0, 0);
        cyc("abort", 1, 0, 1, 4'h3, 0, 0, 3'd0, FETCH0, 0);

        // Every opcode x flags x step
        for (int op = 0; op < 16; op++) begin
            for (int fl = 0; fl < 4; fl++) begin
                logic fc, fz;
                fc = fl[0]; fz = fl[1];
                cyc("sweep_clr", op * 4 + fl, 1, 1, 4'(op), fc, fz, step, '0, 0);
                for (int st = 0; st < 5; st++) begin
                    logic [14:0] e;
                    logic        h;
                    h = (op == 15) && (st == 2);
                    e = h ? 15'd0 : model(4'(op), fc, fz, st);
                    if (op >= 9 && op <= 13) begin
                        clr = 1'b0; step_en = 1'b1; opcode = 4'(op); cf = fc; zf = fz;
                        #1;
                        check("nop_only_fetch", op * 32 + fl * 8 + st,
                              {1'b0, strobes & ~(FETCH0 | FETCH1)}, 16'd0);
                        #1;
                    end
                    cyc("sweep", op * 32 + fl * 8 + st, 0, 1, 4'(op), fc, fz, 3'(st), e, h);
                    if (h) break;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
